// File: rtl/controller_shift_responder_pkg.sv
// -----------------------------------------------------------------------------
// controller_pkg
//
// Shared definitions for the game-pad responder:
//   - ctrl_state_e   : responder FSM states (IDLE, LOAD, SHIFT, DONE)
//   - BTN_*          : bit positions of each button in the 8-bit snapshot
//   - CTRL_NUM_BITS  : bits per frame on the serial line
//   - CTRL_CNT_W     : width of the saturating bit counter (holds 0..8)
//   - shift_released : one shift step of the snapshot register
// -----------------------------------------------------------------------------
package controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int CTRL_NUM_BITS = 8;
    localparam int CTRL_CNT_W    = 4;

    // Bits already sent are replaced by zeros, which read as "released" on the
    // active-low data line once the frame runs past its eighth bit.
    function automatic logic [CTRL_NUM_BITS-1:0] shift_released(
        input logic [CTRL_NUM_BITS-1:0] v
    );
        return v >> 1;
    endfunction

endpackage

// File: rtl/controller_shift_responder_if.sv
// -----------------------------------------------------------------------------
// controller_shift_responder_if
//
// Pad-port bundle between a controller reader (master) and the responder
// (slave).
//   I_LATCH        : latch strobe from the reader (asynchronous)
//   I_PULSE        : shift clock from the reader (asynchronous)
//   I_BUTTONS[7:0] : button state, active-high pressed
//   O_DATA         : serial data, active-low (0 = pressed)
//   O_BIT_COUNT    : bits shifted in the current frame, saturates at 8
//   O_FRAME_DONE   : one-cycle pulse on the 8th shifted bit
//   O_PROTOCOL_ERR : one-cycle pulse on an aborted frame or early pulse
// -----------------------------------------------------------------------------
interface controller_shift_responder_if;
    import controller_pkg::*;

    logic                     I_LATCH;
    logic                     I_PULSE;
    logic [CTRL_NUM_BITS-1:0] I_BUTTONS;
    logic                     O_DATA;
    logic [CTRL_CNT_W-1:0]    O_BIT_COUNT;
    logic                     O_FRAME_DONE;
    logic                     O_PROTOCOL_ERR;

    modport master (
        output I_LATCH,
        output I_PULSE,
        output I_BUTTONS,
        input  O_DATA,
        input  O_BIT_COUNT,
        input  O_FRAME_DONE,
        input  O_PROTOCOL_ERR
    );

    modport slave (
        input  I_LATCH,
        input  I_PULSE,
        input  I_BUTTONS,
        output O_DATA,
        output O_BIT_COUNT,
        output O_FRAME_DONE,
        output O_PROTOCOL_ERR
    );

endinterface

// File: rtl/controller_shift_responder_strobe_sync_filter.sv
// -----------------------------------------------------------------------------
// strobe_sync_filter
//
// Brings one asynchronous strobe into the clock domain, debounces it and
// reports edges of the debounced level.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   raw  : asynchronous strobe input
//   rise : high for one cycle after the filtered level goes 0 -> 1
//   fall : high for one cycle after the filtered level goes 1 -> 0
//
// Latency from a stable raw edge to rise/fall is SYNC_STAGES + FILTER_CYCLES
// clocks.
// -----------------------------------------------------------------------------
module strobe_sync_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   synced;
    logic                   filt_p1;
    logic                   filt_p2;
    logic [CNT_W-1:0]       cnt;

    // Synchronizer chain; the last stage is the first usable copy of the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_p0[SYNC_STAGES-1];

    // Level filter: the counter tracks how long the synchronized value has
    // disagreed with the accepted level; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_p1 <= 1'b0;
            cnt     <= '0;
        end else if (synced == filt_p1) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            filt_p1 <= synced;
            cnt     <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Edge detect on the filtered level only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_p2 <= 1'b0;
        end else begin
            filt_p2 <= filt_p1;
        end
    end

    assign rise = filt_p1 & ~filt_p2;
    assign fall = ~filt_p1 & filt_p2;

endmodule

// File: rtl/controller_shift_responder.sv
// -----------------------------------------------------------------------------
// controller_shift_responder
//
// Game-pad side of the serial controller protocol. A latch strobe snapshots
// the buttons, each pulse strobe then shifts the next button onto the
// active-low data line.
//   I_CLK_33MHZ : system clock
//   I_RESET     : asynchronous active-high reset
//   bus         : pad port (strobes and buttons in; data, count, flags out)
//
// All outputs are registered; a strobe edge reaches them
// SYNC_STAGES + FILTER_CYCLES + 1 clocks after the raw edge.
// -----------------------------------------------------------------------------
module controller_shift_responder
    import controller_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                         I_CLK_33MHZ,
    input  logic                         I_RESET,
    controller_shift_responder_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_LOAD  = ST_LOAD;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam logic [CTRL_CNT_W-1:0] CNT_LAST = CTRL_CNT_W'(CTRL_NUM_BITS - 1);
    localparam logic [CTRL_CNT_W-1:0] CNT_FULL = CTRL_CNT_W'(CTRL_NUM_BITS);

    logic                     latch_rise;
    logic                     latch_fall;
    logic                     pulse_rise;
    logic                     pulse_fall;
    logic                     unused_pulse_fall;

    logic [1:0]               state;
    logic [CTRL_NUM_BITS-1:0] shreg;
    logic [CTRL_CNT_W-1:0]    bit_count;
    logic                     data;
    logic                     frame_done;
    logic                     protocol_err;

    strobe_sync_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_latch_filter (
        .clk  (I_CLK_33MHZ),
        .rst  (I_RESET),
        .raw  (bus.I_LATCH),
        .rise (latch_rise),
        .fall (latch_fall)
    );

    strobe_sync_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_pulse_filter (
        .clk  (I_CLK_33MHZ),
        .rst  (I_RESET),
        .raw  (bus.I_PULSE),
        .rise (pulse_rise),
        .fall (pulse_fall)
    );

    // Only the leading edge of a pulse advances the frame.
    assign unused_pulse_fall = pulse_fall;

    always_ff @(posedge I_CLK_33MHZ or posedge I_RESET) begin
        if (I_RESET) begin
            state        <= S_IDLE;
            shreg        <= '0;
            bit_count    <= '0;
            data         <= 1'b1;
            frame_done   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            frame_done   <= 1'b0;
            protocol_err <= 1'b0;

            if (latch_rise) begin
                // A latch always restarts the frame; a pulse edge in the same
                // cycle is dropped silently. Re-latching part way through a
                // frame is reported as an abort.
                protocol_err <= (state == S_SHIFT) && (bit_count < CNT_FULL);
                state        <= S_LOAD;
                shreg        <= bus.I_BUTTONS;
                data         <= ~bus.I_BUTTONS[BTN_A];
                bit_count    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        data <= 1'b1;
                    end
                    S_LOAD: begin
                        // Snapshot tracks the buttons until the latch drops.
                        shreg     <= bus.I_BUTTONS;
                        data      <= ~bus.I_BUTTONS[BTN_A];
                        bit_count <= '0;
                        if (pulse_rise) begin
                            protocol_err <= 1'b1;
                        end
                        if (latch_fall) begin
                            state <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (pulse_rise) begin
                            shreg     <= shift_released(shreg);
                            bit_count <= bit_count + CTRL_CNT_W'(1);
                            if (bit_count == CNT_LAST) begin
                                state      <= S_DONE;
                                frame_done <= 1'b1;
                                data       <= 1'b1;
                            end else begin
                                // Bit 1 of the current snapshot is bit 0
                                // after this shift.
                                data <= ~shreg[BTN_B];
                            end
                        end
                    end
                    S_DONE: begin
                        data <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.O_DATA         = data;
    assign bus.O_BIT_COUNT    = bit_count;
    assign bus.O_FRAME_DONE   = frame_done;
    assign bus.O_PROTOCOL_ERR = protocol_err;

endmodule

// File: tb/tb_controller_shift_responder.sv
// -----------------------------------------------------------------------------
// tb_controller_shift_responder
//
// Drives latch/pulse frames into controller_shift_responder. Each stimulus
// step queues the output change it should cause; a monitor watches for any
// change of O_DATA/O_BIT_COUNT or a flag pulse and compares against the queue.
// -----------------------------------------------------------------------------
module tb_controller_shift_responder;
    import controller_pkg::*;

    typedef struct packed {
        logic       data;
        logic [3:0] count;
        logic       done;
        logic       err;
    } obs_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    obs_t exp_q[$];

    controller_shift_responder_if bus();

    controller_shift_responder #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4)
    ) dut (
        .I_CLK_33MHZ (clk),
        .I_RESET     (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #15 clk = ~clk;

    // ---------------- monitor ----------------
    logic       prev_data;
    logic [3:0] prev_count;

    always @(negedge clk) begin
        obs_t cur;
        obs_t e;
        if (rst) begin
            prev_data  = 1'b1;
            prev_count = 4'd0;
        end else begin
            cur = '{data: bus.O_DATA, count: bus.O_BIT_COUNT,
                    done: bus.O_FRAME_DONE, err: bus.O_PROTOCOL_ERR};
            if (cur.data !== prev_data || cur.count !== prev_count || cur.done || cur.err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event t=%0t got data=%b count=%0d done=%b err=%b",
                             $time, cur.data, cur.count, cur.done, cur.err);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        failures++;
                        $display("FAIL event t=%0t got data=%b count=%0d done=%b err=%b want data=%b count=%0d done=%b err=%b",
                                 $time, cur.data, cur.count, cur.done, cur.err,
                                 e.data, e.count, e.done, e.err);
                    end
                end
            end
            prev_data  = cur.data;
            prev_count = cur.count;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic d, input logic [3:0] c, input logic dn, input logic er);
        obs_t o;
        o = '{data: d, count: c, done: dn, err: er};
        exp_q.push_back(o);
    endtask

    // Events for pulses first..last of a frame whose snapshot is b.
    task automatic expect_shift(input logic [7:0] b, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            if (k == 8) push(1'b1, 4'd8, 1'b1, 1'b0);
            else        push(~b[k], 4'(k), 1'b0, 1'b0);
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.I_PULSE = 1'b1;
            tick(10);
            bus.I_PULSE = 1'b0;
            tick(10);
        end
    endtask

    task automatic latch_frame(input logic [7:0] b);
        bus.I_BUTTONS = b;
        push(~b[0], 4'd0, 1'b0, 1'b0);
        bus.I_LATCH = 1'b1;
        tick(12);
        bus.I_LATCH = 1'b0;
        tick(12);
    endtask

    task automatic wait_drain(input int bound, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_%s pending=%0d want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        if (bus.O_DATA !== 1'b1 || bus.O_BIT_COUNT !== 4'd0 ||
            bus.O_FRAME_DONE !== 1'b0 || bus.O_PROTOCOL_ERR !== 1'b0) begin
            failures++;
            $display("FAIL %s got data=%b count=%0d done=%b err=%b want data=1 count=0 done=0 err=0",
                     tag, bus.O_DATA, bus.O_BIT_COUNT, bus.O_FRAME_DONE, bus.O_PROTOCOL_ERR);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.I_LATCH   = 1'b0;
        bus.I_PULSE   = 1'b0;
        bus.I_BUTTONS = 8'h00;
        tick(3);
        check_outputs("reset_state");
        rst = 1'b0;
        tick(20);
        check_outputs("idle_quiet");

        // Pulses while idle: ignored, no error.
        pulses(2);
        wait_drain(50, "idle_pulses");

        // 8'h81: data 0,1,1,1,1,1,1,0 then 1 with done.
        latch_frame(8'h81);
        expect_shift(8'h81, 1, 8);
        pulses(8);
        wait_drain(50, "frame_81");

        // Extra pulses after the frame: nothing moves.
        pulses(2);
        wait_drain(50, "done_extra");

        // Snapshot frozen: buttons drop to 0 after the latch falls.
        latch_frame(8'hFF);
        bus.I_BUTTONS = 8'h00;
        expect_shift(8'hFF, 1, 8);
        pulses(8);
        wait_drain(50, "frame_ff_frozen");

        // Abort after 3 pulses, then re-latch.
        latch_frame(8'h3C);
        expect_shift(8'h3C, 1, 3);
        pulses(3);
        wait_drain(50, "abort_pre");
        push(1'b1, 4'd0, 1'b0, 1'b1);
        bus.I_LATCH = 1'b1;
        tick(12);
        bus.I_LATCH = 1'b0;
        tick(12);
        wait_drain(50, "abort");

        // 2-clock glitch on pulse: filtered out.
        bus.I_PULSE = 1'b1;
        tick(2);
        bus.I_PULSE = 1'b0;
        tick(20);
        wait_drain(10, "glitch");

        // Finish the re-latched frame.
        expect_shift(8'h3C, 1, 8);
        pulses(8);
        wait_drain(50, "frame_3c");

        // Pulse while latch is held high: error, no shift.
        bus.I_BUTTONS = 8'hA7;
        push(1'b0, 4'd0, 1'b0, 1'b0);
        bus.I_LATCH = 1'b1;
        tick(12);
        push(1'b0, 4'd0, 1'b0, 1'b1);
        pulses(1);
        bus.I_LATCH = 1'b0;
        tick(12);
        wait_drain(50, "pulse_in_load");

        // Four pulses then asynchronous reset mid-frame.
        expect_shift(8'hA7, 1, 4);
        pulses(4);
        wait_drain(50, "pre_reset");
        #5;
        rst = 1'b1;
        #1;
        check_outputs("async_reset_midframe");
        tick(3);
        check_outputs("reset_held");
        rst = 1'b0;
        tick(5);

        // Fresh frame after reset.
        latch_frame(8'h55);
        expect_shift(8'h55, 1, 8);
        pulses(8);
        wait_drain(200, "frame_55");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall watchdog.
    initial begin
        #3000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
